// File: rtl/car_controller.sv
// car_controller: single elevator car that travels floor by floor, stops for matching calls,
// holds the door open for a dwell time and pulses clear masks for the calls it served.
module car_controller #(
  parameter int FLOOR_TICKS = 8,
  parameter int DOOR_TICKS  = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  nextDirection,
  input  logic [13:0] floorButton,
  input  logic [7:1]  internalButton,
  output logic [2:0]  currentFloor,
  output logic [1:0]  currentDirection,
  output logic        move,
  output logic        doorState,
  output logic [13:0] clearFloorButton,
  output logic [7:1]  clearInternalButton
);
  localparam int MAXT = FLOOR_TICKS > DOOR_TICKS ? FLOOR_TICKS : DOOR_TICKS;
  localparam int CW = $clog2(MAXT) + 1;
  localparam logic [CW-1:0] TRAVEL_LOAD = CW'(FLOOR_TICKS - 1);
  localparam logic [CW-1:0] DWELL_LOAD = CW'(DOOR_TICKS - 1);
  localparam logic [1:0] STOP = 2'b00, UP = 2'b10, DOWN = 2'b01;
  localparam logic [13:0] UP_BITS = 14'h2AAA, DOWN_BITS = 14'h1555;
  typedef enum logic [1:0] {IDLE, TRAVEL, ARRIVE, OPEN} state_t;
  state_t state_q;
  logic [2:0] floor_q;
  logic [1:0] dir_q;
  logic move_q, door_q;
  logic [CW-1:0] travel_q, dwell_q;
  logic [13:0] clr_fb_q, mask_fb_q;
  logic [7:1] clr_in_q, mask_in_q;
  logic [1:0] next_dir;
  logic [7:1] cab_bit;
  logic [13:0] hall_both, arr_fb;
  logic cab, edge_floor, idle_call, go_travel, arr_match, pulsing, retrig;
  logic [2:0] floor_d;
  always_comb begin
    next_dir = nextDirection == 2'b11 ? STOP : nextDirection;
    cab_bit = 7'(1) << (floor_q - 3'd1);
    hall_both = 14'(3) << {floor_q - 3'd1, 1'b0};
    cab = |(internalButton & cab_bit);
    edge_floor = floor_q == 3'd1 || floor_q == 3'd7;
    arr_fb = floorButton & hall_both &
             ((UP_BITS & {14{dir_q == UP || edge_floor}}) | (DOWN_BITS & {14{dir_q == DOWN || edge_floor}}));
    arr_match = cab || |arr_fb;
    idle_call = cab || |(floorButton & hall_both);
    go_travel = (next_dir == UP && floor_q < 3'd7) || (next_dir == DOWN && floor_q > 3'd1);
    floor_d = dir_q == UP && floor_q < 3'd7 ? floor_q + 3'd1 :
              dir_q == DOWN && floor_q > 3'd1 ? floor_q - 3'd1 : floor_q;
    // A button still lit during its own clear pulse is the old call, not a new press.
    pulsing = |clr_fb_q || |clr_in_q;
    retrig = !pulsing && (|(floorButton & mask_fb_q) || |(internalButton & mask_in_q));
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      floor_q <= 3'd1;
      dir_q <= STOP;
      move_q <= 1'b0;
      door_q <= 1'b0;
      travel_q <= '0;
      dwell_q <= '0;
      clr_fb_q <= '0;
      clr_in_q <= '0;
      mask_fb_q <= '0;
      mask_in_q <= '0;
    end else if (!enable) begin
      clr_fb_q <= '0;
      clr_in_q <= '0;
    end else begin
      clr_fb_q <= '0;
      clr_in_q <= '0;
      case (state_q)
        IDLE: begin
          dir_q <= next_dir;
          if (idle_call) begin
            state_q <= OPEN;
            door_q <= 1'b1;
            dwell_q <= DWELL_LOAD;
            mask_fb_q <= hall_both;
            mask_in_q <= cab_bit;
            clr_fb_q <= hall_both;
            clr_in_q <= cab_bit;
          end else if (go_travel) begin
            state_q <= TRAVEL;
            move_q <= 1'b1;
            travel_q <= TRAVEL_LOAD;
          end
        end
        TRAVEL: begin
          if (travel_q == '0) begin
            state_q <= ARRIVE;
            floor_q <= floor_d;
          end else begin
            travel_q <= travel_q - 1'b1;
          end
        end
        ARRIVE: begin
          move_q <= 1'b0;
          if (arr_match) begin
            state_q <= OPEN;
            door_q <= 1'b1;
            dwell_q <= DWELL_LOAD;
            mask_fb_q <= arr_fb;
            mask_in_q <= cab_bit;
            clr_fb_q <= arr_fb;
            clr_in_q <= cab_bit;
          end else begin
            state_q <= IDLE;
          end
        end
        OPEN: begin
          if (retrig) begin
            dwell_q <= DWELL_LOAD;
            clr_fb_q <= mask_fb_q;
            clr_in_q <= mask_in_q;
          end else if (dwell_q == '0) begin
            state_q <= IDLE;
            door_q <= 1'b0;
          end else begin
            dwell_q <= dwell_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign currentFloor = floor_q;
  assign currentDirection = dir_q;
  assign move = move_q;
  assign doorState = door_q;
  assign clearFloorButton = clr_fb_q;
  assign clearInternalButton = clr_in_q;
endmodule

// File: tb/tb_car_controller.sv
// tb_car_controller: directed scenarios plus random traffic, checked every cycle against a
// floor/phase model built from the call-service rules; call buttons latch until cleared.
module tb_car_controller;
  localparam int FT = 4, DT = 3;
  localparam int P_IDLE = 0, P_TRAVEL = 1, P_ARRIVE = 2, P_OPEN = 3;
  logic clk = 1'b0, reset, enable;
  logic [1:0] nd;
  logic [13:0] fb_b, pend_fb;
  logic [7:1] in_b, pend_in;
  logic [2:0] currentFloor;
  logic [1:0] currentDirection;
  logic move, doorState;
  logic [13:0] clearFloorButton;
  logic [7:1] clearInternalButton;
  int n_pass = 0, n_total = 0;
  bit chk_en = 0;
  int m_phase, m_floor, m_dir, m_trav, m_open;
  logic [13:0] m_clr_fb = '0, m_mask_fb;
  logic [7:1] m_clr_in = '0, m_mask_in;

  car_controller #(.FLOOR_TICKS(FT), .DOOR_TICKS(DT)) dut (
    .clk(clk), .reset(reset), .enable(enable), .nextDirection(nd),
    .floorButton(fb_b), .internalButton(in_b),
    .currentFloor(currentFloor), .currentDirection(currentDirection),
    .move(move), .doorState(doorState),
    .clearFloorButton(clearFloorButton), .clearInternalButton(clearInternalButton)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic open_door(input logic [13:0] hm, input int f);
    m_phase = P_OPEN;
    m_open = 0;
    m_mask_fb = hm;
    m_mask_in = '0;
    m_mask_in[f] = 1'b1;
    m_clr_fb = hm;
    m_clr_in = m_mask_in;
  endtask

  task automatic model_step();
    int f, nxt;
    logic busy, edge_f;
    logic [13:0] hm;
    f = m_floor;
    busy = (m_clr_fb != 0) || (m_clr_in != 0);
    m_clr_fb = '0;
    m_clr_in = '0;
    if (!reset) begin
      m_phase = P_IDLE; m_floor = 1; m_dir = 0; m_trav = 0; m_open = 0;
      return;
    end
    if (!enable) return;
    hm = '0;
    case (m_phase)
      P_IDLE: begin
        m_dir = nd == 2'b10 ? 1 : nd == 2'b01 ? -1 : 0;
        if (in_b[f] || fb_b[2*f-1] || fb_b[2*f-2]) begin
          hm[2*f-1] = 1'b1;
          hm[2*f-2] = 1'b1;
          open_door(hm, f);
        end else if ((m_dir == 1 && f < 7) || (m_dir == -1 && f > 1)) begin
          m_phase = P_TRAVEL;
          m_trav = 0;
        end
      end
      P_TRAVEL: begin
        m_trav++;
        if (m_trav == FT) begin
          nxt = f + m_dir;
          m_floor = nxt < 1 ? 1 : nxt > 7 ? 7 : nxt;
          m_phase = P_ARRIVE;
        end
      end
      P_ARRIVE: begin
        edge_f = f == 1 || f == 7;
        if (fb_b[2*f-1] && (m_dir == 1 || edge_f)) hm[2*f-1] = 1'b1;
        if (fb_b[2*f-2] && (m_dir == -1 || edge_f)) hm[2*f-2] = 1'b1;
        if (in_b[f] || hm != 0) open_door(hm, f);
        else m_phase = P_IDLE;
      end
      default: begin
        if (!busy && ((fb_b & m_mask_fb) != 0 || (in_b & m_mask_in) != 0)) begin
          m_open = 0;
          m_clr_fb = m_mask_fb;
          m_clr_in = m_mask_in;
        end else if (m_open == DT - 1) m_phase = P_IDLE;
        else m_open++;
      end
    endcase
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) if (chk_en) begin
    check("floor", 32'(currentFloor), 32'(m_floor));
    check("dir", 32'(currentDirection), m_dir == 1 ? 32'd2 : m_dir == -1 ? 32'd1 : 32'd0);
    check("move", 32'(move), 32'(m_phase == P_TRAVEL || m_phase == P_ARRIVE));
    check("door", 32'(doorState), 32'(m_phase == P_OPEN));
    check("clr_fb", 32'(clearFloorButton), 32'(m_clr_fb));
    check("clr_in", 32'(clearInternalButton), 32'(m_clr_in));
  end

  // Buttons clear one edge after their pulse, like a real call latch.
  task automatic step();
    @(negedge clk);
    fb_b = fb_b & ~pend_fb;
    in_b = in_b & ~pend_in;
    pend_fb = m_clr_fb;
    pend_in = m_clr_in;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; nd = 2'b00; fb_b = '0; in_b = '0; pend_fb = '0; pend_in = '0;
    step(); step(); chk_en = 1;
    check("rst_floor", 32'(currentFloor), 1);
    check("rst_dir", 32'(currentDirection), 0);
    check("rst_move", 32'(move), 0);
    check("rst_door", 32'(doorState), 0);
    reset = 1'b1; nd = 2'b10; in_b[3] = 1'b1;
    step();
    check("a_move", 32'(move), 1);
    check("a_dir", 32'(currentDirection), 2);
    repeat (4) step();
    check("a_arr2_floor", 32'(currentFloor), 2);
    check("a_arr2_move", 32'(move), 1);
    repeat (6) step();
    check("a_arr3_floor", 32'(currentFloor), 3);
    step();
    check("a_open_door", 32'(doorState), 1);
    check("a_clr_in", 32'(clearInternalButton), 32'h4);
    check("a_open_move", 32'(move), 0);
    nd = 2'b00;
    step();
    check("a_pulse_end", 32'(clearInternalButton), 0);
    check("a_door2", 32'(doorState), 1);
    step();
    check("a_door3", 32'(doorState), 1);
    step();
    check("a_closed", 32'(doorState), 0);
    reset = 1'b0;
    step();
    check("b_rst_floor", 32'(currentFloor), 1);
    reset = 1'b1; fb_b[1] = 1'b1;
    step();
    check("b_door", 32'(doorState), 1);
    check("b_clr_fb", 32'(clearFloorButton), 32'h3);
    check("b_move", 32'(move), 0);
    repeat (3) step();
    check("b_closed", 32'(doorState), 0);
    check("b_floor", 32'(currentFloor), 1);
    nd = 2'b10; fb_b[2] = 1'b1;
    repeat (5) step();
    check("c_arr_floor", 32'(currentFloor), 2);
    check("c_arr_door", 32'(doorState), 0);
    check("c_arr_clr", 32'(clearFloorButton), 0);
    nd = 2'b00;
    step();
    check("c_idle_move", 32'(move), 0);
    check("c_idle_door", 32'(doorState), 0);
    check("c_idle_clr", 32'(clearFloorButton), 0);
    step();
    check("c_open_clr", 32'(clearFloorButton), 32'hC);
    repeat (3) step();
    check("c_closed", 32'(doorState), 0);
    in_b[2] = 1'b1;
    step();
    check("d_clr_in", 32'(clearInternalButton), 32'h2);
    step(); step();
    in_b[2] = 1'b1;
    step();
    check("d_repulse", 32'(clearInternalButton), 32'h2);
    check("d_door_hold", 32'(doorState), 1);
    step(); step();
    check("d_door_ext", 32'(doorState), 1);
    step();
    check("d_closed", 32'(doorState), 0);
    nd = 2'b10; in_b[7] = 1'b1;
    repeat (13) step();
    check("e_floor4", 32'(currentFloor), 4);
    check("e_moving", 32'(move), 1);
    step();
    reset = 1'b0; in_b = '0;
    step();
    check("e_rst_floor", 32'(currentFloor), 1);
    check("e_rst_move", 32'(move), 0);
    check("e_rst_dir", 32'(currentDirection), 0);
    reset = 1'b1; nd = 2'b10;
    repeat (45) step();
    check("f_top_floor", 32'(currentFloor), 7);
    check("f_top_move", 32'(move), 0);
    nd = 2'b01;
    repeat (3) step();
    enable = 1'b0;
    repeat (5) step();
    check("f_frz_floor", 32'(currentFloor), 7);
    check("f_frz_move", 32'(move), 1);
    check("f_frz_dir", 32'(currentDirection), 1);
    enable = 1'b1;
    step();
    check("f_resume_floor", 32'(currentFloor), 7);
    step();
    check("f_arr6_floor", 32'(currentFloor), 6);
    nd = 2'b00;
    repeat (3000) begin
      step();
      reset = $urandom_range(0, 299) != 0;
      enable = $urandom_range(0, 15) != 0;
      if ($urandom_range(0, 7) == 0) nd = 2'($urandom);
      if ($urandom_range(0, 5) == 0) fb_b[$urandom_range(0, 13)] = 1'b1;
      if ($urandom_range(0, 7) == 0) in_b[$urandom_range(1, 7)] = 1'b1;
    end
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
